// File: rtl/bit_scan_serial.sv
// Streaming set-bit enumerator: takes a mask, emits each set-bit index lowest first, one per beat.
// Define BIT_SCAN_OVERLAP_EN to accept the next mask on the same edge as the last index handshake.
module bit_scan_serial #(
  parameter int width = 8,
  parameter int speed = 1   // 0 serial, 1 Brent-Kung, 2 Sklansky prefix-OR
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [width-1:0]         in_mask_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [$clog2(width)-1:0] out_idx_o,
  output logic                     out_last_o
);
  localparam int IW = $clog2(width);
  localparam int LV = $clog2(width);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [width-1:0] r_q, r_d;
  logic [width-1:0] pfx, low, rest;
  logic [IW-1:0]    enc;
  logic             scan, in_hs, out_hs;

  function automatic logic [width-1:0] pfx_serial(input logic [width-1:0] r);
    logic [width-1:0] p;
    p = r;
    for (int i = 1; i < width; i++) p[i] = p[i] | p[i-1];
    return p;
  endfunction

  // Each level folds the lower half-block's last prefix into the whole upper half-block.
  function automatic logic [width-1:0] pfx_sklansky(input logic [width-1:0] r);
    logic [width-1:0] p, q;
    p = r;
    for (int l = 0; l < LV; l++) begin
      q = p;
      for (int i = 0; i < width; i++)
        if (((i >> l) & 1) == 1) q[i] = p[i] | p[((i >> l) << l) - 1];
      p = q;
    end
    return p;
  endfunction

  // Up-sweep builds power-of-two block ORs; down-sweep fills in the remaining positions.
  function automatic logic [width-1:0] pfx_bk(input logic [width-1:0] r);
    logic [width-1:0] p;
    p = r;
    for (int l = 0; l < LV; l++)
      for (int i = 0; i < width; i++)
        if ((i + 1) % (2 << l) == 0) p[i] = p[i] | p[i - (1 << l)];
    for (int l = LV - 2; l >= 0; l--)
      for (int i = 0; i < width; i++)
        if (((i + 1) % (2 << l) == (1 << l)) && (i >= (2 << l))) p[i] = p[i] | p[i - (1 << l)];
    return p;
  endfunction

  if (speed == 0) begin : g_serial
    assign pfx = pfx_serial(r_q);
  end else if (speed == 2) begin : g_sklansky
    assign pfx = pfx_sklansky(r_q);
  end else begin : g_bk
    assign pfx = pfx_bk(r_q);
  end

  assign low  = r_q & ~(pfx << 1);
  assign rest = r_q & ~low;

  always_comb begin
    enc = '0;
    for (int i = 0; i < width; i++)
      if (low[i]) enc = enc | IW'(i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
    end
  end

  always_comb begin
    scan        = (state_q == SCAN);
    out_valid_o = scan;
    out_idx_o   = scan ? enc : '0;
    out_last_o  = scan && (rest == '0);
`ifdef BIT_SCAN_OVERLAP_EN
    in_ready_o  = !rst_i && (!scan || (out_ready_i && out_last_o));
`else
    in_ready_o  = !rst_i && !scan;
`endif
    in_hs   = in_valid_i && in_ready_o;
    out_hs  = scan && out_ready_i;
    state_d = state_q;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
        // zero masks are consumed here and never reach SCAN
        if (in_hs && (in_mask_i != '0)) begin
          r_d     = in_mask_i;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (out_hs) begin
          r_d = rest;
          if (rest == '0) begin
            state_d = IDLE;
            r_d     = '0;
`ifdef BIT_SCAN_OVERLAP_EN
            if (in_hs && (in_mask_i != '0)) begin
              r_d     = in_mask_i;
              state_d = SCAN;
            end
`endif
          end
        end
      end
      default: begin
        state_d = IDLE;
        r_d     = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_bit_scan_serial.sv
// Scoreboard bench for bit_scan_serial: directed cases on a width-8 instance, then random
// traffic on widths 5/8/13 across all three prefix-OR structures.
module tb_bit_scan_serial;
  localparam int NI = 9;
  localparam int WS [NI] = '{8, 5, 5, 5, 8, 8, 13, 13, 13};
  localparam int SP [NI] = '{1, 0, 1, 2, 0, 2, 0, 1, 2};
`ifdef BIT_SCAN_OVERLAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 2;
`endif

  typedef struct { int idx; bit last; int cyc; } beat_t;
  typedef struct { int cyc; int kind; int val; } probe_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NI-1:0]       vld = '0;
  logic [NI-1:0]       ordy = '1;
  logic [NI-1:0][15:0] mask_b = '0;
  logic [NI-1:0]       ir, ov, olast;
  logic [NI-1:0][3:0]  oidx;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [$clog2(WS[g])-1:0] idx_w;
    bit_scan_serial #(.width(WS[g]), .speed(SP[g])) u_dut (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(vld[g]), .in_ready_o(ir[g]), .in_mask_i(mask_b[g][WS[g]-1:0]),
      .out_valid_o(ov[g]), .out_ready_i(ordy[g]), .out_idx_o(idx_w), .out_last_o(olast[g]));
    assign oidx[g] = 4'(idx_w);
  end

  beat_t  sbq [NI][$];
  probe_t pq[$];
  bit [NI-1:0] auto_push = '0;
  bit done = 1'b0;
  int n_chk = 0, n_fail = 0;

  // Reference: ascending list of set bits; the final one carries last.
  function automatic void push_mask(int g, logic [15:0] m, int t);
    int idxs[$];
    for (int i = 0; i < WS[g]; i++) if (m[i]) idxs.push_back(i);
    foreach (idxs[k]) sbq[g].push_back('{idxs[k], (k == idxs.size() - 1), (t < 0) ? -1 : t + k});
  endfunction

  function automatic bit all_empty();
    for (int g = 0; g < NI; g++) if (sbq[g].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic probe(int off, int kind, int val);
    pq.push_back('{cyc + off, kind, val});
  endtask

  task automatic step(output bit [NI-1:0] hs);
    @(negedge clk);
    hs = vld & ir;
    @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) if (hs[g] && auto_push[g]) push_mask(g, mask_b[g], -1);
  endtask

  task automatic chk(bit ok, string name, int act, int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  initial begin : monitor
    bit [NI-1:0] p_hold;
    logic [NI-1:0][3:0] p_idx;
    logic [NI-1:0] p_last;
    probe_t pr;
    beat_t e;
    p_hold = '0;
    forever begin
      @(negedge clk);
      while (pq.size() > 0 && pq[0].cyc <= cyc) begin
        pr = pq.pop_front();
        if (pr.kind == 0) chk(int'(ir[0]) == pr.val, "in_ready", int'(ir[0]), pr.val);
        else              chk(int'(ov[0]) == pr.val, "out_valid", int'(ov[0]), pr.val);
      end
      for (int g = 0; g < NI; g++) begin
        if (rst) chk(ir[g] == 1'b0, $sformatf("in_ready during reset g%0d", g), int'(ir[g]), 0);
        if (p_hold[g])
          chk(ov[g] && oidx[g] == p_idx[g] && olast[g] == p_last[g],
              $sformatf("hold stable g%0d (valid,idx*2+last)", g),
              int'(ov[g]) * 100 + int'(oidx[g]) * 2 + int'(olast[g]),
              100 + int'(p_idx[g]) * 2 + int'(p_last[g]));
        if (ov[g] && ordy[g]) begin
          chk(sbq[g].size() > 0, $sformatf("unexpected beat g%0d idx", g), int'(oidx[g]), -1);
          if (sbq[g].size() > 0) begin
            e = sbq[g].pop_front();
            chk(oidx[g] == 4'(e.idx) && olast[g] == e.last,
                $sformatf("beat g%0d idx*2+last", g),
                int'(oidx[g]) * 2 + int'(olast[g]), e.idx * 2 + int'(e.last));
            if (e.cyc >= 0) chk(cyc == e.cyc, $sformatf("beat cycle g%0d", g), cyc, e.cyc);
          end
        end else if (!ov[g]) begin
          chk(oidx[g] == 4'd0 && olast[g] == 1'b0, $sformatf("idle outputs zero g%0d", g),
              int'(oidx[g]) * 2 + int'(olast[g]), 0);
        end
        p_hold[g] = ov[g] && !ordy[g] && !rst;
        p_idx[g]  = oidx[g];
        p_last[g] = olast[g];
      end
      if (done) begin
        for (int g = 0; g < NI; g++)
          chk(sbq[g].size() == 0, $sformatf("missing beats g%0d", g), sbq[g].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    end
  end

  initial begin : stim
    bit [NI-1:0] hs;
    int t;
    // reset
    probe(1, 0, 0); probe(1, 1, 0);
    step(hs);
    rst = 1'b0;
    probe(0, 0, 1); probe(0, 1, 0);
    step(hs);

    // 0xA4 -> 2, 5, 7(last)
    vld[0] = 1'b1; mask_b[0] = 16'h00A4;
    step(hs); t = cyc; vld[0] = 1'b0;
    push_mask(0, 16'h00A4, t);
    probe(0, 0, 0); probe(2, 0, (GAP == 1) ? 1 : 0); probe(3, 0, 1); probe(3, 1, 0);
    repeat (3) step(hs);

    // zero mask dropped, then 0x10 -> 4(last)
    vld[0] = 1'b1; mask_b[0] = 16'h0000;
    step(hs); t = cyc;
    probe(0, 0, 1); probe(0, 1, 0);
    mask_b[0] = 16'h0010;
    step(hs); vld[0] = 1'b0;
    push_mask(0, 16'h0010, t + 1);
    probe(1, 0, 1);
    step(hs);

    // 0x81 with three cycles of backpressure
    vld[0] = 1'b1; mask_b[0] = 16'h0081;
    step(hs); t = cyc; vld[0] = 1'b0; ordy[0] = 1'b0;
    sbq[0].push_back('{0, 1'b0, t + 3});
    sbq[0].push_back('{7, 1'b1, t + 4});
    probe(1, 0, 0);
    repeat (3) step(hs);
    ordy[0] = 1'b1;
    repeat (2) step(hs);

    // back-to-back 0x01, 0x80
    vld[0] = 1'b1; mask_b[0] = 16'h0001;
    step(hs); t = cyc; mask_b[0] = 16'h0080;
    push_mask(0, 16'h0001, t);
    push_mask(0, 16'h0080, t + GAP);
    for (int k = 0; k < 4; k++) begin
      step(hs);
      if (hs[0]) break;
    end
    vld[0] = 1'b0;
    repeat (3) step(hs);

    // reset in the middle of 0xFF
    vld[0] = 1'b1; mask_b[0] = 16'h00FF;
    step(hs); t = cyc; vld[0] = 1'b0;
    for (int i = 0; i < 3; i++) sbq[0].push_back('{i, 1'b0, t + i});
    repeat (2) step(hs);
    rst = 1'b1;
    probe(0, 0, 0);
    step(hs);
    rst = 1'b0;
    probe(0, 1, 0); probe(0, 0, 1); probe(1, 1, 0);
    repeat (4) step(hs);

    // random traffic on every instance
    auto_push = '1;
    repeat (2500) begin
      step(hs);
      for (int g = 0; g < NI; g++) begin
        vld[g]  = ($urandom_range(0, 3) != 0);
        ordy[g] = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 7))
          0:       mask_b[g] = 16'h0000;
          1:       mask_b[g] = 16'(1) << $urandom_range(0, WS[g] - 1);
          2:       mask_b[g] = 16'hFFFF;
          default: mask_b[g] = 16'($urandom);
        endcase
      end
    end

    vld = '0; ordy = '1;
    for (int k = 0; k < 200 && !all_empty(); k++) step(hs);
    step(hs);
    done = 1'b1;
  end
endmodule
